// File: rtl/draw_source_scheduler_if.sv
// Shared draw-manager bus between the scheduler (master) and its draw sources (slave).
interface draw_source_scheduler_if #(
    parameter int SOURCE_SEL_ADDRW  = 2,
    parameter int COLOR_DEPTH       = 12,
    parameter int DRAW_WIDTH_ADDRW  = 9,
    parameter int DRAW_HEIGHT_ADDRW = 8
);
    logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
    logic                         write_awaited;
    logic                         write_active;
    logic                         write_transparent;
    logic [COLOR_DEPTH-1:0]       write_color_data;
    logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr;
    logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;

    modport master (
        output write_source_sel, write_awaited,
        input  write_active, write_transparent, write_color_data, write_x_addr, write_y_addr
    );

    modport slave (
        input  write_source_sel, write_awaited,
        output write_active, write_transparent, write_color_data, write_x_addr, write_y_addr
    );
endinterface

// File: rtl/draw_source_scheduler.sv
// Per-frame painter's-order arbiter for the shared draw bus; forwards granted pixels to the back framebuffer.
// Optional per-source watchdog enabled by defining DRAW_SCHED_TIMEOUT_EN.
module draw_source_scheduler #(
    parameter int SOURCE_COUNT      = 4,
    parameter int SOURCE_SEL_ADDRW  = 2,
    parameter int TIMEOUT_CYCLES    = 65536,
    parameter int COLOR_DEPTH       = 12,
    parameter int DRAW_WIDTH_ADDRW  = 9,
    parameter int DRAW_HEIGHT_ADDRW = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic [SOURCE_COUNT-1:0]      source_enable,
    draw_source_scheduler_if.master      bus,
    output logic                         fb_we,
    output logic [DRAW_WIDTH_ADDRW-1:0]  fb_x,
    output logic [DRAW_HEIGHT_ADDRW-1:0] fb_y,
    output logic [COLOR_DEPTH-1:0]       fb_color,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         frame_overrun,
    output logic [SOURCE_COUNT-1:0]      timeout_mask
);
    localparam int CW = SOURCE_SEL_ADDRW + 1;

    if (SOURCE_COUNT < 2 || SOURCE_COUNT > (1 << SOURCE_SEL_ADDRW) ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 131071) begin : g_bad_cfg
        $error("draw_source_scheduler: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_SELECT, S_AWAIT, S_DRAW, S_NEXT, S_DONE
    } state_t;

    state_t                      state, state_nx;
    logic [CW-1:0]               cur;
    logic [SOURCE_COUNT-1:0]     en_q;
    logic [SOURCE_SEL_ADDRW-1:0] sel_q;
    logic                        found;
    logic [SOURCE_SEL_ADDRW-1:0] found_id;
    logic                        in_window;
    logic                        timeout_hit;
    logic                        pix_take;
    logic                        frame_accept;

    assign in_window    = (state == S_AWAIT) || (state == S_DRAW);
    assign frame_accept = (state == S_IDLE) && frame_start;
    assign pix_take     = in_window && bus.write_active && !bus.write_transparent && !timeout_hit;

    // Lowest latched-enabled source at or above the scan cursor.
    always_comb begin
        found    = 1'b0;
        found_id = '0;
        for (int unsigned i = 0; i < SOURCE_COUNT; i++) begin
            if (!found && en_q[i] && (CW'(i) >= cur)) begin
                found    = 1'b1;
                found_id = SOURCE_SEL_ADDRW'(i);
            end
        end
    end

`ifdef DRAW_SCHED_TIMEOUT_EN
    logic [16:0] to_cnt;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in AWAIT+DRAW for the current grant.
    assign timeout_hit = in_window && (to_cnt == 17'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt       <= '0;
            timeout_mask <= '0;
        end else begin
            if (state == S_SELECT) to_cnt <= '0;
            else if (in_window)    to_cnt <= to_cnt + 17'd1;
            if (frame_accept)      timeout_mask <= '0;
            else if (timeout_hit)  timeout_mask[sel_q] <= 1'b1;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_mask = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (frame_start) state_nx = S_SCAN;
            S_SCAN:   state_nx = found ? S_SELECT : S_DONE;
            S_SELECT: state_nx = S_AWAIT;
            S_AWAIT: begin
                if (timeout_hit)           state_nx = S_NEXT;
                else if (bus.write_active) state_nx = S_DRAW;
            end
            S_DRAW: begin
                if (timeout_hit || !bus.write_active) state_nx = S_NEXT;
            end
            S_NEXT:   state_nx = S_SCAN;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.write_awaited    = (state == S_AWAIT);
        bus.write_source_sel = sel_q;
        busy                 = (state != S_IDLE);
        frame_done           = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur           <= '0;
            en_q          <= '0;
            sel_q         <= '0;
            fb_we         <= 1'b0;
            fb_x          <= '0;
            fb_y          <= '0;
            fb_color      <= '0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= frame_start && (state != S_IDLE);
            if (frame_accept) begin
                en_q <= source_enable;
                cur  <= '0;
            end
            if (state == S_SCAN && found) sel_q <= found_id;
            if (state == S_NEXT)          cur   <= CW'(sel_q) + CW'(1);
            fb_we <= pix_take;
            if (pix_take) begin
                fb_x     <= bus.write_x_addr;
                fb_y     <= bus.write_y_addr;
                fb_color <= bus.write_color_data;
            end
        end
    end
endmodule

// File: tb/tb_draw_source_scheduler.sv
// Directed + randomized bench for draw_source_scheduler with a behavioural bus-source model.
module tb_draw_source_scheduler;
    localparam int SC = 4;
    localparam int SW = 2;
    localparam int CD = 12;
    localparam int XW = 9;
    localparam int YW = 8;
`ifdef DRAW_SCHED_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 65536;
`endif

    typedef struct {
        int            cyc;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CD-1:0] c;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic [SC-1:0] source_enable;
    logic          fb_we;
    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y;
    logic [CD-1:0] fb_color;
    logic          busy, frame_done, frame_overrun;
    logic [SC-1:0] timeout_mask;

    draw_source_scheduler_if #(
        .SOURCE_SEL_ADDRW(SW), .COLOR_DEPTH(CD), .DRAW_WIDTH_ADDRW(XW), .DRAW_HEIGHT_ADDRW(YW)
    ) bus ();

    draw_source_scheduler #(
        .SOURCE_COUNT(SC), .SOURCE_SEL_ADDRW(SW), .TIMEOUT_CYCLES(TO),
        .COLOR_DEPTH(CD), .DRAW_WIDTH_ADDRW(XW), .DRAW_HEIGHT_ADDRW(YW)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .source_enable(source_enable),
        .bus(bus), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
        .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun),
        .timeout_mask(timeout_mask)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    pix_t exp_q[$];
    int   grant_q[$];
    int   done_cnt, done_cyc, ovr_cnt, ovr_seen_cyc, we_cnt, last_fs;
    int   aw_cycles[SC];
    bit   prev_aw;
    bit   src_on, drawing;
    int   left, pix_i, delay, tr_mode;
    int   burst_len[SC];
    logic [SC-1:0] silent;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.write_active      = 1'b0;
        bus.write_transparent = 1'bx;
        bus.write_color_data  = 'z;
        bus.write_x_addr      = 'z;
        bus.write_y_addr      = 'z;
    endtask

    // Draw source: waits a random delay after being awaited, then bursts burst_len pixels back-to-back.
    task automatic drive_source();
        pix_t p;
        bit   tr;
        if (!drawing && bus.write_awaited === 1'b1 && !silent[bus.write_source_sel]) begin
            if (delay > 0) delay--;
            else begin
                drawing = 1;
                left    = burst_len[bus.write_source_sel];
                pix_i   = 0;
            end
        end
        if (drawing) begin
            if (left > 0) begin
                p.cyc = cyc + 1;
                p.x   = XW'($urandom);
                p.y   = YW'($urandom);
                p.c   = CD'($urandom);
                tr    = (tr_mode == 1) ? ($urandom_range(0, 7) == 0) : (tr_mode == 2 && pix_i == 7);
                bus.write_active      = 1'b1;
                bus.write_transparent = tr;
                bus.write_x_addr      = p.x;
                bus.write_y_addr      = p.y;
                bus.write_color_data  = p.c;
                if (!tr) exp_q.push_back(p);
                left--;
                pix_i++;
            end else begin
                idle_bus();
                drawing = 0;
                delay   = $urandom_range(0, 2);
            end
        end else begin
            idle_bus();
        end
    endtask

    task automatic tick();
        pix_t p;
        bit   exp_we;
        @(negedge clk);
        cyc++;
        exp_we = (exp_q.size() > 0 && exp_q[0].cyc == cyc);
        check("fb_we", fb_we, exp_we);
        if (exp_we) begin
            p = exp_q.pop_front();
            check("fb_x", fb_x, p.x);
            check("fb_y", fb_y, p.y);
            check("fb_color", fb_color, p.c);
            we_cnt++;
        end
        if (frame_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (frame_overrun === 1'b1) begin ovr_cnt++; ovr_seen_cyc = cyc; end
        if (bus.write_awaited === 1'b1) begin
            if (!prev_aw) grant_q.push_back(int'(bus.write_source_sel));
            aw_cycles[bus.write_source_sel]++;
        end
        prev_aw = (bus.write_awaited === 1'b1);
        if (src_on) drive_source();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, bus.write_source_sel, 0);
        check({tag, "_awaited"}, bus.write_awaited, 0);
        check({tag, "_fb_we"}, fb_we, 0);
        check({tag, "_fb_x"}, fb_x, 0);
        check({tag, "_fb_y"}, fb_y, 0);
        check({tag, "_fb_color"}, fb_color, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_overrun"}, frame_overrun, 0);
        check({tag, "_tmask"}, timeout_mask, 0);
    endtask

    task automatic run_pass(input logic [SC-1:0] en, input bit inject_ovr, input int budget);
        int exp_g[$];
        int ovr_cyc;
        bit ovr_sent;
        grant_q.delete();
        done_cnt = 0; ovr_cnt = 0; we_cnt = 0; ovr_cyc = -10; ovr_sent = 0;
        for (int i = 0; i < SC; i++) aw_cycles[i] = 0;
        for (int i = 0; i < SC; i++) if (en[i]) exp_g.push_back(i);
        frame_start   = 1'b1;
        source_enable = en;
        last_fs       = cyc;
        tick();
        frame_start   = 1'b0;
        source_enable = SC'($urandom);
        check("busy_start", busy, 1);
        while (done_cnt == 0 && cyc - last_fs < budget) begin
            tick();
            frame_start = 1'b0;
            if (inject_ovr && drawing && !ovr_sent) begin
                frame_start = 1'b1;
                ovr_sent    = 1;
                ovr_cyc     = cyc;
            end
        end
        check("done_in_budget", done_cnt, 1);
        repeat (4) tick();
        check("done_once", done_cnt, 1);
        check("grant_count", grant_q.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < grant_q.size(); i++)
            check("grant_order", grant_q[i], exp_g[i]);
        check("pixels_left", exp_q.size(), 0);
        check("busy_end", busy, 0);
        check("overrun_cnt", ovr_cnt, inject_ovr ? 1 : 0);
        if (inject_ovr) check("overrun_cyc", ovr_seen_cyc, ovr_cyc + 1);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; source_enable = '0;
        src_on = 0; drawing = 0; delay = 0; tr_mode = 0; silent = '0; prev_aw = 0;
        for (int i = 0; i < SC; i++) burst_len[i] = 3;
        idle_bus();
        repeat (3) tick();
        check_reset_outputs("por");
        rst = 1'b0;
        src_on = 1;
        tick();

        // Reset while source 0 is mid-burst
        burst_len[0] = 40;
        frame_start = 1'b1; source_enable = 4'b0001;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 40 && !(drawing && pix_i >= 5); i++) tick();
        check("reached_draw", drawing, 1);
        rst = 1'b1; src_on = 0; exp_q.delete();
        bus.write_active = 1'b1; bus.write_transparent = 1'b0;
        tick();
        check_reset_outputs("midreset");
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("post_reset_busy", busy, 0);
        drawing = 0; delay = 0; src_on = 1;
        idle_bus();
        tick();

        // Sources 0 and 2, three pixels each
        for (int i = 0; i < SC; i++) burst_len[i] = 3;
        tr_mode = 0;
        run_pass(4'b0101, 0, 200);
        check("we_count_0101", we_cnt, 6);
        check("src1_never_awaited", aw_cycles[1], 0);

        // No enabled sources
        run_pass(4'b0000, 0, 50);
        check("empty_done_t2", done_cyc, last_fs + 2);

        // Long starfield-style burst with one transparent pixel
        burst_len[0] = 51; tr_mode = 2;
        run_pass(4'b0001, 0, 300);
        check("we_count_51", we_cnt, 50);

        // frame_start while drawing
        tr_mode = 0;
        for (int i = 0; i < SC; i++) burst_len[i] = $urandom_range(2, 6);
        run_pass(4'b0110, 1, 200);

        // Randomized passes
        tr_mode = 1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < SC; i++) burst_len[i] = $urandom_range(1, 6);
            run_pass(SC'($urandom), 0, 300);
            check("tmask_clear", timeout_mask, 0);
        end

`ifdef DRAW_SCHED_TIMEOUT_EN
        // Source 0 never answers; watchdog skips it
        tr_mode = 0; silent = 4'b0001; burst_len[1] = 3;
        run_pass(4'b0011, 0, 200);
        check("timeout_mask", timeout_mask, 4'b0001);
        check("timeout_await_len", aw_cycles[0], TO);
        check("timeout_src1_px", we_cnt, 3);
        silent = '0;
        run_pass(4'b0010, 0, 200);
        check("timeout_mask_cleared", timeout_mask, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
